// File: rtl/uart_pkg.sv
// Shared types and helpers for the configuration-link UART receiver.
package uart_pkg;

    localparam int unsigned UART_WIDTH_DEF = 18;
    localparam int unsigned UART_OSR_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_t;

    // True when the XOR of all word bits equals the selected parity sense.
    // Narrower words are zero-extended by the caller, which leaves the XOR intact.
    function automatic logic parity_ok(input logic [31:0] word, input logic odd);
        return (^word) == odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered head, valid flag and fill count.
module sync_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           valid,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem   [DEPTH];
    logic [WIDTH-1:0] mem_n [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_n, rd_n;
    logic             do_push, do_pop;

    // Pointer MSB differs with equal index bits only when full.
    assign full_c = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);

    // Next storage and pointer values; a pop frees a slot for a same-cycle push.
    always_comb begin
        mem_n   = mem;
        wr_n    = wr_ptr;
        rd_n    = rd_ptr;
        do_pop  = pop && (wr_ptr != rd_ptr);
        do_push = push && (!full_c || do_pop);
        if (do_push) begin
            mem_n[wr_ptr[AW-1:0]] = push_data;
            wr_n                  = wr_ptr + PW'(1);
        end
        if (do_pop) begin
            rd_n = rd_ptr + PW'(1);
        end
    end

    // Storage, pointers and registered show-ahead outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
            valid  <= 1'b0;
            count  <= '0;
        end else begin
            mem    <= mem_n;
            wr_ptr <= wr_n;
            rd_ptr <= rd_n;
            head   <= mem_n[rd_n[AW-1:0]];
            valid  <= (wr_n != rd_n);
            count  <= CW'(wr_n - rd_n);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with runt, parity and framing checks, feeding a
// show-ahead FIFO. Define UART_RX_MAJORITY_EN for 3-sample majority bit voting.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH      = UART_WIDTH_DEF,
    parameter int unsigned OSR        = UART_OSR_DEF,
    parameter int unsigned DEPTH      = 4,
    parameter bit          PARITY_ODD = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       rx_in,
    output logic [WIDTH-1:0]           rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [$clog2(DEPTH+1)-1:0] rx_count,
    output logic                       runt,
    output logic                       parity_err,
    output logic                       frame_err,
    output logic                       overrun
);

    localparam int unsigned CNT_W = $clog2(OSR + 1);
    localparam int unsigned BIT_W = $clog2(WIDTH);
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned START_TH = OSR / 2;
`else
    localparam int unsigned START_TH = OSR / 2 - 1;
`endif

    logic             sync1, line, line_q;
    logic             samp_c;
    uart_rx_state_t   state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [BIT_W-1:0] bit_cnt, bit_n;
    logic [WIDTH-1:0] shreg, sh_n;
    logic             runt_n, parity_n, frame_n, overrun_n;
    logic             push_c, pop_c, full_c;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b1;
            line   <= 1'b1;
            line_q <= 1'b1;
        end else begin
            sync1  <= rx_in;
            line   <= sync1;
            line_q <= line;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Two previous synchronised samples for the centre-1/centre/centre+1 vote.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], line};
        end
    end

    assign samp_c = (hist[1] & hist[0]) | (hist[1] & line) | (hist[0] & line);
`else
    assign samp_c = line;
`endif

    assign pop_c = rx_ready && rx_valid;

    // FSM, bit counters, shifter and registered error pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            runt       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_n;
            shreg      <= sh_n;
            runt       <= runt_n;
            parity_err <= parity_n;
            frame_err  <= frame_n;
            overrun    <= overrun_n;
        end
    end

    // Next-state decode: bit timing, sampling decisions and FIFO push.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_n     = bit_cnt;
        sh_n      = shreg;
        runt_n    = 1'b0;
        parity_n  = 1'b0;
        frame_n   = 1'b0;
        overrun_n = 1'b0;
        push_c    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (line_q && !line) begin
                    state_n = ST_START;
                end
            end
            ST_START: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(START_TH)) begin
                    if (samp_c) begin
                        runt_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n   = '0;
                        bit_n   = '0;
                        state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(OSR - 1)) begin
                    cnt_n = '0;
                    sh_n  = {samp_c, shreg[WIDTH-1:1]};
                    if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                        bit_n   = '0;
                        state_n = ST_STOP;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(OSR - 1)) begin
                    cnt_n = '0;
                    if (samp_c) begin
                        state_n = ST_IDLE;
                        if (!parity_ok(32'(shreg), PARITY_ODD)) begin
                            parity_n = 1'b1;
                        end else if (full_c && !pop_c) begin
                            overrun_n = 1'b1;
                        end else begin
                            push_c = 1'b1;
                        end
                    end else begin
                        frame_n = 1'b1;
                        state_n = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_n = '0;
                if (line) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_c),
        .push_data (shreg),
        .pop       (pop_c),
        .head      (rx_data),
        .valid     (rx_valid),
        .count     (rx_count),
        .full_c    (full_c)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo with a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned W     = 18;
    localparam int unsigned OSR   = 16;
    localparam int unsigned DEPTH = 4;
    localparam bit          PODD  = 1'b1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    // Clocks from driving the start edge to the frame result being visible:
    // 2 synchroniser + OSR/2 to start check + (W+1)*OSR to stop sample + 1 write.
    localparam int LAT      = 2 + OSR / 2 + (W + 1) * OSR + 1;
    // Clocks from a runt falling edge to the visible runt pulse.
    localparam int RUNT_LAT = 2 + OSR / 2 + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_in;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [CW-1:0] rx_count;
    logic          runt, parity_err, frame_err, overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0] q[$];

    uart_rx_fifo #(
        .WIDTH      (W),
        .OSR        (OSR),
        .DEPTH      (DEPTH),
        .PARITY_ODD (PODD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_count   (rx_count),
        .runt       (runt),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {runt, parity_err, frame_err, overrun};
    endfunction

    function automatic logic [W-1:0] fixp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        if ((^r) != PODD) r[W-1] = ~r[W-1];
        return r;
    endfunction

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_fifo(input string tag);
        chk({tag, "_valid"}, 64'(rx_valid), 64'(q.size() > 0));
        chk({tag, "_count"}, 64'(rx_count), 64'(q.size()));
        if (q.size() > 0) chk({tag, "_data"}, 64'(rx_data), 64'(q[0]));
    endtask

    // Drive a full frame from a negedge; judge the outcome at the result cycle.
    task automatic send_frame(input logic [W-1:0] word, input logic stop_bit, input logic pop_end);
        logic [W+1:0] lv;
        logic [3:0]   exp_p;
        logic         popped;
        lv     = {stop_bit, word, 1'b0};
        popped = 1'b0;
        exp_p  = 4'b0000;
        for (int t = 0; t < int'((W + 2) * OSR); t++) begin
            if (t == LAT - 1) begin
                chk("pre_pulse", 64'(pulses()), 64'(0));
                chk("pre_count", 64'(rx_count), 64'(q.size()));
                if (pop_end && q.size() > 0) begin
                    rx_ready = 1'b1;
                    popped   = 1'b1;
                end
            end
            if (t == LAT) begin
                rx_ready = 1'b0;
                if (popped) void'(q.pop_front());
                if (!stop_bit) exp_p[1] = 1'b1;
                else if ((^word) != PODD) exp_p[2] = 1'b1;
                else if (q.size() == DEPTH) exp_p[0] = 1'b1;
                else q.push_back(word);
                chk("frame_pulse", 64'(pulses()), 64'(exp_p));
                chk_fifo("frame");
            end
            if (t == LAT + 1) chk("post_pulse", 64'(pulses()), 64'(0));
            rx_in = lv[t / OSR];
            @(negedge clk);
        end
    endtask

    // Low glitch shorter than half a bit: must be rejected with one runt pulse.
    task automatic send_runt(input int len);
        for (int t = 0; t < RUNT_LAT + 20; t++) begin
            if (t == RUNT_LAT - 1) chk("runt_pre", 64'(pulses()), 64'(0));
            if (t == RUNT_LAT) begin
                chk("runt_pulse", 64'(pulses()), 64'(4'b1000));
                chk_fifo("runt");
            end
            if (t == RUNT_LAT + 1) chk("runt_post", 64'(pulses()), 64'(0));
            rx_in = (t < len) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic pop_some(input int n);
        for (int i = 0; i < n; i++) begin
            chk_fifo("pop");
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            void'(q.pop_front());
        end
        chk_fifo("pop_end");
    endtask

    initial begin
        logic [W-1:0] w;
        int           kind;
        logic         stop;

        reset_n  = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pulse", 64'(pulses()), 64'(0));
        chk("rst_valid", 64'(rx_valid), 64'(0));
        chk("rst_count", 64'(rx_count), 64'(0));
        chk("rst_data", 64'(rx_data), 64'(0));
        reset_n = 1'b1;
        idle(5);

        // Good frame, then runt followed by a good frame.
        send_frame(18'h2AB57, 1'b1, 1'b0);
        idle(5);
        send_runt(5);
        send_frame(fixp(18'h0F0F0), 1'b1, 1'b0);
        idle(5);

        // Parity error: word dropped.
        send_frame(18'h0AB57, 1'b1, 1'b0);
        idle(5);

        // Low stop bit, line held low, then a recoverable frame.
        send_frame(18'h2AB57, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (100) @(negedge clk);
        chk("break_pulse", 64'(pulses()), 64'(0));
        chk("break_count", 64'(rx_count), 64'(q.size()));
        idle(10);
        send_frame(18'h00001, 1'b1, 1'b0);
        idle(5);
        pop_some(q.size());

        // Five words into a four-deep FIFO: fifth overruns.
        for (int i = 1; i <= 5; i++) begin
            send_frame(fixp(18'h20000 | W'(i)), 1'b1, 1'b0);
            idle(3);
        end
        pop_some(q.size());

        // Pop while empty is ignored.
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk_fifo("empty_pop");

        // Full FIFO: push and pop in the same cycle, no overrun.
        for (int i = 0; i < int'(DEPTH); i++) begin
            send_frame(fixp(W'($urandom)), 1'b1, 1'b0);
            idle(2);
        end
        send_frame(fixp(W'($urandom)), 1'b1, 1'b1);
        idle(3);

        // Reset in the middle of the data bits.
        w = fixp(W'($urandom));
        rx_in = 1'b0;
        repeat (OSR) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            rx_in = w[b];
            repeat (OSR) @(negedge clk);
        end
        reset_n = 1'b0;
        rx_in   = 1'b1;
        repeat (3) @(negedge clk);
        q.delete();
        chk("mid_rst_pulse", 64'(pulses()), 64'(0));
        chk("mid_rst_data", 64'(rx_data), 64'(0));
        chk_fifo("mid_rst");
        reset_n = 1'b1;
        idle(10);
        chk_fifo("mid_rst_after");
        send_frame(w, 1'b1, 1'b0);
        idle(5);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 14; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                send_runt(int'($urandom_range(1, 6)));
            end else begin
                w    = W'($urandom);
                if (kind > 2) w = fixp(w);
                stop = (kind != 9);
                send_frame(w, stop, 1'($urandom_range(0, 1)));
                if (!stop) begin
                    rx_in = 1'b0;
                    repeat (int'($urandom_range(0, 30))) @(negedge clk);
                end
                idle(int'($urandom_range(4, 30)));
            end
            if (q.size() > 0 && $urandom_range(0, 2) == 0)
                pop_some(int'($urandom_range(1, q.size())));
        end
        pop_some(q.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
